// File: rtl/life_stage_manager.sv
// life_stage_manager
//   Owns lives, stage index, remaining bricks and score for the brick-breaker
//   game. Responds to the game controller (start / relaunch pulses in, life
//   count and stage-cleared pulse out). It takes event pulses from the
//   collision and brick logic and drives registered status to the controller
//   and the display path.
//
// Ports
//   i_clk               system clock
//   i_rst               synchronous, active-high reset
//   i_disp_startgame    pulse: game begins (honoured only in IDLE)
//   i_game_start        pulse: relaunch after a stage clear (honoured in CLEAR)
//   i_life_loss         pulse: ball lost
//   i_brick_hit         pulse: one brick destroyed
//   o_life_count        current lives
//   o_brick_next_stage  one-cycle pulse: stage cleared, another stage follows
//   o_stage             current stage, 0-based
//   o_bricks_left       bricks remaining in the current stage
//   o_score             accumulated score (saturating)
//   o_game_over         level: lives exhausted
//   o_game_won          level: last stage cleared
//
// Optional feature macro: LIFE_STAGE_EXTRA_LIFE_EN
//   When defined, a bonus life is granted each time the score reaches the
//   next multiple of EXTRA_LIFE_SCORE. When undefined, score never affects lives.
module life_stage_manager #(
   parameter int LIVES_INIT       = 3,
   parameter int NUM_STAGES       = 4,
   parameter int BRICKS_PER_STAGE = 40,
   parameter int POINTS_PER_BRICK = 10,
   parameter int SCORE_W          = 16,
   parameter int EXTRA_LIFE_SCORE = 500,
   localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
   localparam int BRICK_W = $clog2(BRICKS_PER_STAGE + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_disp_startgame,
   input  logic               i_game_start,
   input  logic               i_life_loss,
   input  logic               i_brick_hit,
   output logic [2:0]         o_life_count,
   output logic               o_brick_next_stage,
   output logic [STAGE_W-1:0] o_stage,
   output logic [BRICK_W-1:0] o_bricks_left,
   output logic [SCORE_W-1:0] o_score,
   output logic               o_game_over,
   output logic               o_game_won
);

   if (LIVES_INIT < 1 || LIVES_INIT > 7 || EXTRA_LIFE_SCORE < 1) begin : g_bad_param
      $error("life_stage_manager: LIVES_INIT must be 1..7 and EXTRA_LIFE_SCORE positive");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_CLEAR = 3'd2,
      ST_OVER  = 3'd3,
      ST_WIN   = 3'd4
   } state_t;

   localparam logic [2:0]         LIVES_LOAD  = 3'(LIVES_INIT);
   localparam logic [BRICK_W-1:0] BRICKS_LOAD = BRICK_W'(BRICKS_PER_STAGE);
   localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(NUM_STAGES - 1);

   // Score plus one brick's worth, clamped at the all-ones maximum.
   function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] v);
      logic [SCORE_W:0] s;
      s = {1'b0, v} + (SCORE_W + 1)'(POINTS_PER_BRICK);
      return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   function automatic logic [2:0] sat_inc_lives(input logic [2:0] v);
      return (v == 3'd7) ? 3'd7 : v + 3'd1;
   endfunction

   function automatic logic [2:0] sat_dec_lives(input logic [2:0] v);
      return (v == 3'd0) ? 3'd0 : v - 3'd1;
   endfunction

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_lives, w_lives_nxt;
   logic [STAGE_W-1:0] r_stage, w_stage_nxt;
   logic [BRICK_W-1:0] r_bricks, w_bricks_nxt;
   logic [SCORE_W-1:0] r_score, w_score_nxt;
   logic               r_next_stage, w_next_stage_nxt;
   logic               r_over, w_over_nxt;
   logic               r_won, w_won_nxt;

   logic [SCORE_W-1:0] w_score_add;
   logic               w_last_brick;
   logic               w_loss_eff;
   logic               w_bonus;

   assign w_score_add  = sat_add_score(r_score);
   assign w_last_brick = i_brick_hit && (r_bricks == BRICK_W'(1));
   // A last-brick hit wins over a simultaneous life loss.
   assign w_loss_eff   = i_life_loss && !w_last_brick;

`ifdef LIFE_STAGE_EXTRA_LIFE_EN
   localparam logic [SCORE_W:0] THRESH_STEP = (SCORE_W + 1)'(EXTRA_LIFE_SCORE);

   // One extra bit so the threshold can sit beyond a saturated score.
   logic [SCORE_W:0] r_thresh, w_thresh_nxt;

   always_comb begin
      w_bonus      = 1'b0;
      w_thresh_nxt = r_thresh;
      if (r_state == ST_IDLE && i_disp_startgame) begin
         w_thresh_nxt = THRESH_STEP;
      end else if (r_state == ST_PLAY && i_brick_hit && ({1'b0, w_score_add} >= r_thresh)) begin
         w_bonus      = 1'b1;
         w_thresh_nxt = r_thresh + THRESH_STEP;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_thresh <= THRESH_STEP;
      else       r_thresh <= w_thresh_nxt;
   end
`else
   assign w_bonus = 1'b0;
`endif

   always_comb begin
      w_state_nxt      = r_state;
      w_lives_nxt      = r_lives;
      w_stage_nxt      = r_stage;
      w_bricks_nxt     = r_bricks;
      w_score_nxt      = r_score;
      w_next_stage_nxt = 1'b0;
      w_over_nxt       = r_over;
      w_won_nxt        = r_won;

      unique case (r_state)
         ST_IDLE: begin
            if (i_disp_startgame) begin
               w_lives_nxt  = LIVES_LOAD;
               w_stage_nxt  = '0;
               w_bricks_nxt = BRICKS_LOAD;
               w_score_nxt  = '0;
               w_over_nxt   = 1'b0;
               w_won_nxt    = 1'b0;
               w_state_nxt  = ST_PLAY;
            end
         end

         ST_PLAY: begin
            if (i_brick_hit) begin
               w_bricks_nxt = r_bricks - BRICK_W'(1);
               w_score_nxt  = w_score_add;
            end
            if (w_last_brick) begin
               if (r_stage == LAST_STAGE) begin
                  w_state_nxt = ST_WIN;
                  w_won_nxt   = 1'b1;
               end else begin
                  w_state_nxt      = ST_CLEAR;
                  w_next_stage_nxt = 1'b1;
               end
            end
            // Bonus and loss in the same cycle cancel out.
            if (w_bonus && !w_loss_eff) begin
               w_lives_nxt = sat_inc_lives(r_lives);
            end else if (w_loss_eff && !w_bonus) begin
               w_lives_nxt = sat_dec_lives(r_lives);
               if (r_lives <= 3'd1) begin
                  w_state_nxt = ST_OVER;
                  w_over_nxt  = 1'b1;
               end
            end
         end

         ST_CLEAR: begin
            if (i_game_start) begin
               w_stage_nxt  = r_stage + STAGE_W'(1);
               w_bricks_nxt = BRICKS_LOAD;
               w_state_nxt  = ST_PLAY;
            end
         end

         default: begin
            // OVER / WIN are terminal until reset.
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_lives      <= LIVES_LOAD;
         r_stage      <= '0;
         r_bricks     <= BRICKS_LOAD;
         r_score      <= '0;
         r_next_stage <= 1'b0;
         r_over       <= 1'b0;
         r_won        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_lives      <= w_lives_nxt;
         r_stage      <= w_stage_nxt;
         r_bricks     <= w_bricks_nxt;
         r_score      <= w_score_nxt;
         r_next_stage <= w_next_stage_nxt;
         r_over       <= w_over_nxt;
         r_won        <= w_won_nxt;
      end
   end

   assign o_life_count       = r_lives;
   assign o_brick_next_stage = r_next_stage;
   assign o_stage            = r_stage;
   assign o_bricks_left      = r_bricks;
   assign o_score            = r_score;
   assign o_game_over        = r_over;
   assign o_game_won         = r_won;

endmodule

// File: tb/tb_life_stage_manager.sv
// Bench for life_stage_manager (default build, SCORE_W reduced to 10 so the
// score saturation boundary is reachable within one game).
module tb_life_stage_manager;

   localparam int SW = 10;
   localparam int SCORE_MAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sg = 1'b0, gs = 1'b0, ll = 1'b0, bh = 1'b0;
   logic [2:0]    life;
   logic          nxt;
   logic [1:0]    stage;
   logic [5:0]    bricks;
   logic [SW-1:0] score;
   logic          over, won;

   always #5 clk = ~clk;

   life_stage_manager #(.SCORE_W(SW)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_disp_startgame   (sg),
      .i_game_start       (gs),
      .i_life_loss        (ll),
      .i_brick_hit        (bh),
      .o_life_count       (life),
      .o_brick_next_stage (nxt),
      .o_stage            (stage),
      .o_bricks_left      (bricks),
      .o_score            (score),
      .o_game_over        (over),
      .o_game_won         (won)
   );

   typedef struct {
      bit r, s, g, l, b;
      int lives, stg, brk, scr;
      bit nx, ov, wn;
   } vec_t;

   typedef struct {
      int lives, stg, brk, scr;
      bit nx, ov, wn;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;

   // Reference model state: 0 idle, 1 play, 2 clear, 3 over, 4 win
   int m_st, m_lives, m_stage, m_bricks, m_score;
   bit m_nxt, m_over, m_won;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, nm, act, exp);
      end
   endfunction

   function automatic int sat_score(int v);
      return (v + 10 > SCORE_MAX) ? SCORE_MAX : v + 10;
   endfunction

   function automatic void model_step(bit r, bit s, bit g, bit l, bit b);
      m_nxt = 1'b0;
      if (r) begin
         m_st = 0; m_lives = 3; m_stage = 0; m_bricks = 40; m_score = 0;
         m_over = 1'b0; m_won = 1'b0;
      end else begin
         case (m_st)
            0: if (s) begin
                  m_st = 1; m_lives = 3; m_stage = 0; m_bricks = 40; m_score = 0;
               end
            1: begin
                  if (b && m_bricks == 1) begin
                     m_bricks = 0;
                     m_score  = sat_score(m_score);
                     if (m_stage == 3) begin m_st = 4; m_won = 1'b1; end
                     else begin m_st = 2; m_nxt = 1'b1; end
                  end else begin
                     if (b) begin m_bricks--; m_score = sat_score(m_score); end
                     if (l) begin
                        if (m_lives > 0) m_lives--;
                        if (m_lives == 0) begin m_st = 3; m_over = 1'b1; end
                     end
                  end
               end
            2: if (g) begin m_stage++; m_bricks = 40; m_st = 1; end
            default: ;
         endcase
      end
   endfunction

   task automatic pop_and_compare();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         check("life_count", 32'(life), 32'(e.lives));
         check("stage", 32'(stage), 32'(e.stg));
         check("bricks_left", 32'(bricks), 32'(e.brk));
         check("score", 32'(score), 32'(e.scr));
         check("brick_next_stage", 32'(nxt), 32'(e.nx));
         check("game_over", 32'(over), 32'(e.ov));
         check("game_won", 32'(won), 32'(e.wn));
      end
   endtask

   task automatic drive(bit r, bit s, bit g, bit l, bit b);
      @(negedge clk);
      rst = r; sg = s; gs = g; ll = l; bh = b;
   endtask

   task automatic step_vec(vec_t v);
      exp_t e;
      drive(v.r, v.s, v.g, v.l, v.b);
      e.lives = v.lives; e.stg = v.stg; e.brk = v.brk; e.scr = v.scr;
      e.nx = v.nx; e.ov = v.ov; e.wn = v.wn;
      sbq.push_back(e);
      pop_and_compare();
   endtask

   task automatic step(bit r, bit s, bit g, bit l, bit b);
      exp_t e;
      drive(r, s, g, l, b);
      model_step(r, s, g, l, b);
      e.lives = m_lives; e.stg = m_stage; e.brk = m_bricks; e.scr = m_score;
      e.nx = m_nxt; e.ov = m_over; e.wn = m_won;
      sbq.push_back(e);
      pop_and_compare();
   endtask

   task automatic hits(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   vec_t tbl [16];

   initial begin
      //            r  s  g  l  b  lives stg brk scr nx ov wn
      tbl[0]  = '{1, 0, 0, 0, 0, 3, 0, 40,  0, 0, 0, 0};  // reset
      tbl[1]  = '{0, 0, 0, 0, 1, 3, 0, 40,  0, 0, 0, 0};  // hit in IDLE ignored
      tbl[2]  = '{0, 0, 0, 1, 0, 3, 0, 40,  0, 0, 0, 0};  // loss in IDLE ignored
      tbl[3]  = '{0, 0, 1, 0, 0, 3, 0, 40,  0, 0, 0, 0};  // relaunch in IDLE ignored
      tbl[4]  = '{0, 1, 0, 0, 0, 3, 0, 40,  0, 0, 0, 0};  // start -> PLAY
      tbl[5]  = '{0, 0, 0, 0, 1, 3, 0, 39, 10, 0, 0, 0};
      tbl[6]  = '{0, 0, 0, 1, 0, 2, 0, 39, 10, 0, 0, 0};
      tbl[7]  = '{0, 0, 0, 1, 1, 1, 0, 38, 20, 0, 0, 0};  // both applied
      tbl[8]  = '{0, 0, 1, 0, 0, 1, 0, 38, 20, 0, 0, 0};  // relaunch in PLAY
      tbl[9]  = '{0, 1, 0, 0, 0, 1, 0, 38, 20, 0, 0, 0};  // start in PLAY
      tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 38, 20, 0, 0, 0};
      tbl[11] = '{0, 0, 0, 1, 0, 0, 0, 38, 20, 0, 1, 0};  // lives 0 -> over
      tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 38, 20, 0, 1, 0};
      tbl[13] = '{0, 0, 0, 0, 1, 0, 0, 38, 20, 0, 1, 0};
      tbl[14] = '{0, 1, 0, 0, 0, 0, 0, 38, 20, 0, 1, 0};
      tbl[15] = '{1, 0, 0, 0, 0, 3, 0, 40,  0, 0, 0, 0};  // reset clears over

      repeat (2) @(posedge clk);
      for (int i = 0; i < 16; i++) step_vec(tbl[i]);

      // Full game through all stages, score saturating, win with coincident loss
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      hits(40);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      hits(40);
      step(0, 0, 1, 0, 0);          // relaunch right after the pulse
      hits(40);
      step(0, 0, 1, 0, 0);
      hits(39);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);          // lives now 1
      step(0, 0, 0, 1, 1);          // last brick of last stage + loss
      step(0, 0, 0, 1, 1);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);

      // Reset in the middle of stage 2 with score 850
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      hits(40);
      step(0, 0, 1, 0, 0);
      hits(40);
      step(0, 0, 1, 0, 0);
      hits(5);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);          // back in IDLE: ignored
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
